// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD subtractor.
//   BCD_NDIG     default number of BCD digits per operand
//   bcd_digit_t  one packed BCD digit (4 bits)
//   bcd_state_t  control FSM states: IDLE (accepting), CALC (one digit
//                per cycle, LSD first), DONE (result presented)
package bcd_pkg;

    localparam int BCD_NDIG = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor with borrow (purely combinational).
//   a_d   minuend digit
//   b_d   subtrahend digit
//   bin   borrow into this digit
//   d     difference digit (t + 10 when the raw difference is negative)
//   bout  borrow out of this digit
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a_d,
    input  bcd_digit_t b_d,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    // Five signed bits cover every case, including non-BCD digits
    // (range -16..15), so nothing wraps before the correction.
    logic signed [4:0] t;
    logic signed [4:0] t_adj;

    always_comb begin
        t     = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bin});
        t_adj = t + 5'sd10;
        if (t < 0) begin
            d    = t_adj[3:0];
            bout = 1'b1;
        end else begin
            d    = t[3:0];
            bout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: diff = (a - b - bin) mod 10^NDIG.
// One digit is processed per clock, least significant first, so a result
// appears NDIG cycles after the request is accepted.
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (ready only in IDLE)
//   a, b, bin            minuend, subtrahend, borrow-in (captured on accept)
//   out_valid/out_ready  result handshake (valid only in DONE)
//   diff, bout, err      registered result; err flags a non-BCD operand digit
//                        and forces diff and bout to zero
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = BCD_NDIG
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] diff,
    output logic              bout,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    function automatic logic has_bad_digit(input logic [W-1:0] x);
        for (int i = 0; i < NDIG; i++) begin
            if (x[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    bcd_state_t     state;
    logic [IW-1:0]  idx;
    logic           borrow;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   work;
    logic           err_cap;

    bcd_digit_t     d_dig;
    logic           b_dig;
    logic [W-1:0]   next_work;

    // Operands shift right each CALC cycle so the current digit is always
    // in the low nibble; each result digit enters at the top of work and
    // after NDIG shifts the LSD has reached bit 0.
    bcd_digit_sub u_digit (
        .a_d  (a_sh[3:0]),
        .b_d  (b_sh[3:0]),
        .bin  (borrow),
        .d    (d_dig),
        .bout (b_dig)
    );

    always_comb begin
        next_work = (work >> 4) | (W'(d_dig) << (W - 4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            borrow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        borrow   <= bin;
                        err_cap  <= has_bad_digit(a) | has_bad_digit(b);
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    borrow <= b_dig;
                    work   <= next_work;
                    idx    <= idx + 1'b1;
                    if (idx == IW'(NDIG - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        diff      <= err_cap ? '0 : next_work;
                        bout      <= err_cap ? 1'b0 : b_dig;
                        err       <= err_cap;
                    end
                end
                DONE: begin
                    // in_ready stays low through the consume cycle; it rises
                    // together with the return to IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 The block SHALL have one parameter: NDIG, default 4, the number of BCD digits per operand (range 1..8).
REQ-002 clk  input  1  the single clock; every register SHALL update on its rising edge.
REQ-003 rst  input  1  the reset; it SHALL be synchronous and active-high.
REQ-004 in_valid  input  1  the request is valid.
REQ-005 in_ready  output  1  the block can accept a request.
REQ-006 a  input  4*NDIG  the minuend, packed BCD, least significant digit in a[3:0].
REQ-007 b  input  4*NDIG  the subtrahend, packed BCD.
REQ-008 bin  input  1  the borrow-in.
REQ-009 out_valid  output  1  the result is valid.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 diff  output  4*NDIG  the difference, packed BCD (ten's-complement on underflow).
REQ-012 bout  output  1  the borrow-out (a < b + bin).
REQ-013 err  output  1  a captured operand digit was greater than 9.

Function
REQ-014 The block SHALL compute diff = (a - b - bin) mod 10^NDIG, with bout = 1 when (a - b - bin) < 0.
REQ-015 The FSM SHALL have three states.
  - IDLE: in_ready=1.
  - CALC: one digit per cycle, LSD first.
  - DONE: out_valid=1.
REQ-016 The accept event SHALL be in_valid & in_ready at a rising edge; it SHALL capture a, b and bin, clear the digit index, and move the FSM to CALC.
REQ-017 Inputs a, b and bin SHALL be ignored while not in IDLE.
REQ-018 In CALC, each edge SHALL process digit i:
  - t = a_i - b_i - borrow.
  - If t < 0: d_i = t + 10 and borrow = 1.
  - Else: d_i = t and borrow = 0.
  - Borrow SHALL initialise to bin.
REQ-019 The digit index SHALL increment per CALC edge; the edge processing digit NDIG-1 SHALL move the FSM to DONE.
REQ-020 out_valid SHALL assert exactly NDIG rising edges after the accept edge.
REQ-021 In DONE:
  - diff, bout and err SHALL remain stable while out_ready=0.
  - On out_valid & out_ready, the FSM SHALL return to IDLE.
  - in_ready SHALL be 0 during that same cycle (no same-cycle re-accept).
REQ-022 The next request SHALL be acceptable on the edge following the return to IDLE; the throughput limit SHALL be one operation per NDIG+2 cycles.
REQ-023 err SHALL be computed at capture: 1 if any 4-bit digit of a or b exceeds 9.
REQ-024 When err=1, the block SHALL still spend NDIG CALC cycles, and SHALL force diff to all zeros and bout to 0 in DONE.
REQ-025 All digit arithmetic SHALL use 5-bit signed intermediates; no intermediate value SHALL wrap.
REQ-026 diff, bout and err SHALL be registered outputs; they SHALL hold their last value while the FSM is in IDLE and CALC.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set:
  - state to IDLE;
  - in_ready to 1;
  - out_valid to 0;
  - diff, bout and err to 0;
  - digit index and borrow to 0.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation; no out_valid SHALL follow for that request.
REQ-029 in_valid SHALL be ignored on any edge where rst=1.

Structure
REQ-030 The shared package bcd_pkg SHALL contain:
  - the default-digit constant BCD_NDIG=4;
  - the 4-bit typedef bcd_digit_t;
  - the FSM state enum (IDLE, CALC, DONE).
REQ-031 The block SHALL instantiate one combinational sub-module, bcd_digit_sub, with inputs (a_d, b_d, bin) and outputs (d, bout), used once per cycle in the serial path.

Verification
REQ-032 The bench SHALL cover, with the clock named clk and the synchronous active-high reset named rst, these scenarios:
  - a=0x1234, b=0x0567, bin=0 -> diff=0x0667, bout=0, err=0, out_valid exactly 4 edges after accept.
  - a=0x0000, b=0x0001, bin=0 -> diff=0x9999, bout=1.
  - a=0x5000, b=0x4999, bin=1 -> diff=0x0000, bout=0.
  - a=0x12A4, b=0x0001 -> err=1, diff=0x0000, bout=0, same latency.
  - out_ready held low 3 cycles in DONE -> diff, bout and err stable.
    - in_valid=1 with new operands during that time -> not accepted.
    - In the consume cycle in_ready=0; in_ready=1 in the next cycle.
  - rst=1 for one edge during CALC digit 2 -> IDLE and all outputs 0 on the next cycle.
    - No out_valid follows for the aborted request.
    - A following request a=0x9999, b=0x9999 -> diff=0x0000, bout=0.
